// File: rtl/rgb_mixer_pkg.sv
// Shared definitions for the RGB mixer encoder front end.
// Includes quadrature phase codes, FSM states and the move classifier.
package rgb_mixer_pkg;

  localparam int unsigned DEF_WIDTH           = 8;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 255;
  localparam int unsigned INIT_CYCLES         = 3;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } enc_state_t;

  typedef enum logic [1:0] {
    MOVE_NONE    = 2'd0,
    MOVE_UP      = 2'd1,
    MOVE_DOWN    = 2'd2,
    MOVE_ILLEGAL = 2'd3
  } move_t;

  // Next phase in the up direction: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ph)
      PH_00: nxt = PH_01;
      PH_01: nxt = PH_11;
      PH_11: nxt = PH_10;
      PH_10: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  function automatic move_t classify(input logic [1:0] prev, input logic [1:0] cur);
    move_t m;
    if (prev == cur)                 m = MOVE_NONE;
    else if ((prev ^ cur) == 2'b11)  m = MOVE_ILLEGAL;
    else if (next_up(prev) == cur)   m = MOVE_UP;
    else                             m = MOVE_DOWN;
    return m;
  endfunction

endpackage

// File: rtl/debounce.sv
// One encoder line: 2-FF synchroniser followed by a hold-time debouncer.
// load bypasses the counter so the idle pin level is adopted directly.
module debounce
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic in,
  output logic out
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  // Accept a new level on the DEBOUNCE_CYCLES-th consecutive differing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
      out  <= 1'b0;
    end else begin
      meta <= in;
      sync <= meta;
      if (load) begin
        out <= sync;
        cnt <= '0;
      end else if (sync == out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        out <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_encoder_counter.sv
// Rotary encoder front end: debounced quadrature decode driving a WIDTH-bit level.
// One detent (full quadrature cycle) moves value by STEP.
module quad_encoder_counter
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned WIDTH           = DEF_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STEP            = 1,
  parameter bit          SATURATE        = 1'b0,
  parameter int unsigned RESET_VALUE     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             step_pulse,
  output logic             dir,
  output logic             err_pulse
);

  localparam int unsigned INIT_CNT_W = 2;
  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);
  localparam logic [WIDTH:0]   STEP_X     = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MAX_X      = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] RST_V      = WIDTH'(RESET_VALUE);
  localparam logic [3:0]       ACC_UP_DET = 4'b0100;
  localparam logic [3:0]       ACC_DN_DET = 4'b1100;

  enc_state_t            state, state_n;
  logic [INIT_CNT_W-1:0] init_cnt, init_cnt_n;
  logic                  armed, armed_n;
  logic [2:0]            acc, acc_n;
  logic [3:0]            acc_sum;
  logic [1:0]            pab, pab_n;
  logic [1:0]            ab;
  logic                  stable_a, stable_b;
  logic                  init_load;
  move_t                 move;
  logic [WIDTH-1:0]      value_n;
  logic                  step_n, dir_n, err_n;
  logic [WIDTH:0]        sum_up;
  logic [WIDTH-1:0]      val_up, val_dn;

  assign init_load = (state == INIT);
  assign ab        = {stable_a, stable_b};

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .load  (init_load),
    .in    (enc_a),
    .out   (stable_a)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .load  (init_load),
    .in    (enc_b),
    .out   (stable_b)
  );

  // Candidate values for an up or down detent, wrapped or clamped.
  always_comb begin
    sum_up = {1'b0, value} + STEP_X;
    val_up = sum_up[WIDTH-1:0];
    if (SATURATE && (sum_up > MAX_X)) val_up = MAX_X[WIDTH-1:0];
    val_dn = value - STEP_X[WIDTH-1:0];
    if (SATURATE && ({1'b0, value} < STEP_X)) val_dn = '0;
  end

  // Next state, phase accumulation and detent detection.
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    armed_n    = armed;
    acc_n      = acc;
    pab_n      = ab;
    value_n    = value;
    step_n     = 1'b0;
    dir_n      = dir;
    err_n      = 1'b0;
    move       = MOVE_NONE;
    acc_sum    = {acc[2], acc};
    case (state)
      INIT: begin
        armed_n = 1'b0;
        acc_n   = '0;
        if (init_cnt == INIT_LAST) begin
          state_n    = TRACK;
          init_cnt_n = '0;
        end else begin
          init_cnt_n = init_cnt + INIT_CNT_W'(1);
        end
      end
      TRACK: begin
        // pab lags ab by one cycle after INIT, so the first TRACK cycle only primes it.
        armed_n = 1'b1;
        if (armed) move = classify(pab, ab);
        case (move)
          MOVE_ILLEGAL: begin
            err_n = 1'b1;
            acc_n = '0;
          end
          MOVE_UP, MOVE_DOWN: begin
            acc_sum = {acc[2], acc} + ((move == MOVE_UP) ? 4'h1 : 4'hF);
            if (ab == PH_00) begin
              acc_n = '0;
              if ((acc_sum == ACC_UP_DET) || (acc_sum == ACC_DN_DET)) begin
                step_n = 1'b1;
                dir_n  = (acc_sum == ACC_UP_DET);
                if (enable) value_n = dir_n ? val_up : val_dn;
              end
            end else begin
              acc_n = acc_sum[2:0];
            end
          end
          default: ;
        endcase
      end
      default: state_n = INIT;
    endcase
    if (clear) value_n = RST_V;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_n;
      init_cnt <= init_cnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      acc        <= '0;
      pab        <= '0;
      value      <= RST_V;
      step_pulse <= 1'b0;
      dir        <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      armed      <= armed_n;
      acc        <= acc_n;
      pab        <= pab_n;
      value      <= value_n;
      step_pulse <= step_n;
      dir        <= dir_n;
      err_pulse  <= err_n;
    end
  end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Scoreboard bench for quad_encoder_counter: a wrapping and a saturating instance share stimulus.
module tb_quad_encoder_counter;

  localparam int unsigned W   = 8;
  localparam int          LAT = 7;

  logic         clk = 1'b0;
  logic         reset, enc_a, enc_b, enable, clear;
  logic [W-1:0] value_w, value_s;
  logic         step_w, step_s, dir_w, dir_s, err_w, err_s;

  typedef struct {
    bit           is_err;
    logic [W-1:0] value;
    bit           dir;
    int           cyc;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];

  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           last_edge = 0;
  logic [W-1:0] m_w, m_s;
  bit           m_dir;

  quad_encoder_counter #(
    .WIDTH(W), .DEBOUNCE_CYCLES(4), .STEP(1), .SATURATE(1'b0), .RESET_VALUE(0)
  ) dut_w (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enable(enable), .clear(clear),
    .value(value_w), .step_pulse(step_w), .dir(dir_w), .err_pulse(err_w)
  );

  quad_encoder_counter #(
    .WIDTH(W), .DEBOUNCE_CYCLES(4), .STEP(1), .SATURATE(1'b1), .RESET_VALUE(0)
  ) dut_s (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enable(enable), .clear(clear),
    .value(value_s), .step_pulse(step_s), .dir(dir_s), .err_pulse(err_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cmp_event(input string tag, input exp_t e, input logic is_err,
                           input logic [W-1:0] v, input logic d);
    check({tag, "_is_err"}, 64'(is_err), 64'(e.is_err));
    check({tag, "_value"},  64'(v),      64'(e.value));
    check({tag, "_dir"},    64'(d),      64'(e.dir));
    check({tag, "_cycle"},  64'(cyc),    64'(e.cyc));
  endtask

  // Monitors: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && (step_w || err_w)) begin
      if (q_w.size() == 0) check("w_pending_expectation", 64'(q_w.size()), 64'd1);
      else cmp_event("w", q_w.pop_front(), err_w, value_w, dir_w);
    end
  end

  always @(negedge clk) begin
    if (!reset && (step_s || err_s)) begin
      if (q_s.size() == 0) check("s_pending_expectation", 64'(q_s.size()), 64'd1);
      else cmp_event("s", q_s.pop_front(), err_s, value_s, dir_s);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic [1:0] ab, input int hold);
    {enc_a, enc_b} = ab;
    last_edge = cyc;
    repeat (hold) tick();
  endtask

  task automatic expect_detent(input bit up, input bit cleared);
    exp_t e;
    m_dir = up;
    if (cleared) begin
      m_w = '0;
      m_s = '0;
    end else if (enable) begin
      m_w = up ? m_w + 8'd1 : m_w - 8'd1;
      if (up) m_s = (m_s == 8'hFF) ? m_s : m_s + 8'd1;
      else    m_s = (m_s == 8'h00) ? m_s : m_s - 8'd1;
    end
    e.is_err = 1'b0;
    e.dir    = up;
    e.cyc    = last_edge + LAT;
    e.value  = m_w;
    q_w.push_back(e);
    e.value  = m_s;
    q_s.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.dir    = m_dir;
    e.cyc    = last_edge + LAT;
    e.value  = m_w;
    q_w.push_back(e);
    e.value  = m_s;
    q_s.push_back(e);
  endtask

  // One full detent starting and ending at phase 00.
  task automatic detent(input bit up);
    if (up) begin
      set_ab(2'b01, 10); set_ab(2'b11, 10); set_ab(2'b10, 10);
    end else begin
      set_ab(2'b10, 10); set_ab(2'b11, 10); set_ab(2'b01, 10);
    end
    set_ab(2'b00, 0);
    expect_detent(up, 1'b0);
    repeat (10) tick();
  endtask

  initial begin
    reset = 1'b1; enc_a = 1'b1; enc_b = 1'b1; enable = 1'b1; clear = 1'b0;
    m_w = '0; m_s = '0; m_dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_value", 64'(value_w), 64'd0);
    check("reset_step",  64'(step_w),  64'd0);
    check("reset_err",   64'(err_w),   64'd0);
    check("reset_dir",   64'(dir_w),   64'd0);
    reset = 1'b0;
    repeat (20) tick();
    check("idle_value_w", 64'(value_w), 64'd0);
    check("idle_value_s", 64'(value_s), 64'd0);

    // Up detent from idle 11
    set_ab(2'b10, 10); set_ab(2'b00, 10);
    detent(1'b1);
    check("up_value_w", 64'(value_w), 64'd1);
    check("up_dir_w",   64'(dir_w),   64'd1);

    // Down twice: 1 -> 0 -> wrap 255 / clamp 0
    detent(1'b0);
    detent(1'b0);
    check("down_wrap_w", 64'(value_w), 64'd255);
    check("down_sat_s",  64'(value_s), 64'd0);
    check("down_dir_s",  64'(dir_s),   64'd0);

    // Glitches on A while parked at 10 with three quarter-steps accumulated
    set_ab(2'b01, 10); set_ab(2'b11, 10); set_ab(2'b10, 10);
    set_ab(2'b00, 3);  set_ab(2'b10, 10);
    check("glitch3_value_w", 64'(value_w), 64'd255);
    set_ab(2'b00, 4);
    expect_detent(1'b1, 1'b0);
    set_ab(2'b10, 12); set_ab(2'b00, 10);
    check("glitch4_wrap_w", 64'(value_w), 64'd0);
    check("glitch4_sat_s",  64'(value_s), 64'd1);

    // Illegal double transition, then a clean up detent from 11
    set_ab(2'b11, 0);
    expect_err();
    repeat (10) tick();
    check("err_value_w", 64'(value_w), 64'd0);
    set_ab(2'b10, 10); set_ab(2'b00, 10);
    detent(1'b1);
    check("after_err_w", 64'(value_w), 64'd1);
    check("after_err_s", 64'(value_s), 64'd2);

    // clear coincident with the detent edge
    set_ab(2'b01, 10); set_ab(2'b11, 10); set_ab(2'b10, 10);
    set_ab(2'b00, 6);
    clear = 1'b1;
    expect_detent(1'b1, 1'b1);
    tick();
    clear = 1'b0;
    repeat (10) tick();
    check("clear_value_w", 64'(value_w), 64'd0);
    check("clear_value_s", 64'(value_s), 64'd0);

    // Frozen value: detents still pulse and update dir
    enable = 1'b0;
    repeat (3) detent(1'b0);
    check("frozen_value_w", 64'(value_w), 64'd0);
    check("frozen_dir_w",   64'(dir_w),   64'd0);
    enable = 1'b1;
    detent(1'b0);
    check("final_wrap_w", 64'(value_w), 64'd255);
    check("final_sat_s",  64'(value_s), 64'd0);

    repeat (20) tick();
    check("w_events_left", 64'(q_w.size()), 64'd0);
    check("s_events_left", 64'(q_s.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
